mod_t_counter: RTL and testbench

MOD_T_COUNTER -- requirements
Module: mod_t_counter

---
 rtl/mod_t_counter_pkg.sv | 24 ++
 rtl/mod_t_counter_t_stage.sv | 21 ++
 rtl/mod_t_counter.sv | 89 ++++++++
 tb/tb_mod_t_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_t_counter_pkg.sv
// Shared constants for the modulo counter and its millisecond digit chain.
package mod_t_counter_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MODULUS_DEF = 10;

  // A millisecond counter is three cascaded decade digits.
  localparam int MS_DIGITS = 3;
  localparam int DIGIT_MOD = 10;

  // The action one clock edge takes, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_STEP = 2'd3
  } op_e;

  // A modulus is usable when it has at least two states and every state fits in width bits.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_t_counter_t_stage.sv
// One counter bit built as a toggle flip-flop with asynchronous active-low reset.
module t_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qn
);

  // Flip the stored bit on any edge where t is high; clear immediately while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/mod_t_counter.sv
// Synchronous up/down modulo counter with clear, clamped load and cascade carry.
// The count lives in toggle stages; each stage toggles wherever the next count differs.
module mod_t_counter
  import mod_t_counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MODULUS = MODULUS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_t_counter: MODULUS must lie in 2..2**WIDTH");
  end

  // One extra bit so that MODULUS = 2**WIDTH is representable for the compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

  op_e              op;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t_vec;

  // Resolve the edge action with clear over load over enable.
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
  end

  // Next count; an out-of-range count is pulled back to zero on the first enabled step.
  always_comb begin
    nxt = q;
    case (op)
      OP_CLR:  nxt = '0;
      OP_LOAD: nxt = ({1'b0, d} < MOD_EXT) ? d : Q_MAX;
      OP_STEP: begin
        if ({1'b0, q} >= MOD_EXT) begin
          nxt = '0;
        end else if (up) begin
          nxt = (q == Q_MAX) ? '0 : q + 1'b1;
        end else begin
          nxt = (q == '0) ? Q_MAX : q - 1'b1;
        end
      end
      default: nxt = q;
    endcase
  end

  assign t_vec = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_stage u_stage (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

  // Carry ignores clr/load so a downstream stage sees the same enable it would in a plain chain.
  assign tc = en & ((up & (q == Q_MAX)) | (~up & (q == '0)));

  // Flag the cycle after a genuine wrap; a clear or load on that edge suppresses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc & ~clr & ~load;
    end
  end

endmodule

// File: tb/tb_mod_t_counter.sv
// Randomized and directed checks of mod_t_counter against an arithmetic reference model.
module tb_mod_t_counter;
  import mod_t_counter_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int M = MODULUS_DEF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en, up, clr, load;
  logic [W-1:0] d;
  logic [W-1:0] q, qn;
  logic         tc, wrap;

  logic         c_en = 1'b0, c_clr = 1'b0;
  logic [W-1:0] c_q0, c_q1, c_q2, c_qn0, c_qn1, c_qn2;
  logic         c_tc0, c_tc1, c_tc2, c_w0, c_w1, c_w2;
  logic [W-1:0] zero_d = '0;

  int errors = 0;
  int checks = 0;
  int mq     = 0;
  bit mwrap  = 1'b0;

  always #5 clk = ~clk;

  mod_t_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .d(d), .q(q), .qn(qn), .tc(tc), .wrap(wrap)
  );

  mod_t_counter #(.WIDTH(W), .MODULUS(DIGIT_MOD)) u_c0 (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .clr(c_clr), .load(1'b0),
    .d(zero_d), .q(c_q0), .qn(c_qn0), .tc(c_tc0), .wrap(c_w0)
  );
  mod_t_counter #(.WIDTH(W), .MODULUS(DIGIT_MOD)) u_c1 (
    .clk(clk), .rst(rst), .en(c_tc0), .up(1'b1), .clr(c_clr), .load(1'b0),
    .d(zero_d), .q(c_q1), .qn(c_qn1), .tc(c_tc1), .wrap(c_w1)
  );
  mod_t_counter #(.WIDTH(W), .MODULUS(DIGIT_MOD)) u_c2 (
    .clk(clk), .rst(rst), .en(c_tc1), .up(1'b1), .clr(c_clr), .load(1'b0),
    .d(zero_d), .q(c_q2), .qn(c_qn2), .tc(c_tc2), .wrap(c_w2)
  );

  // Reference model: plain modular arithmetic.
  function automatic int m_next(input int cur, input bit e, input bit u, input bit c,
                                input bit l, input int dv);
    if (c) return 0;
    if (l) return (dv < M) ? dv : M - 1;
    if (e) begin
      if (cur >= M) return 0;
      return u ? (cur + 1) % M : (cur + M - 1) % M;
    end
    return cur;
  endfunction

  function automatic bit m_tc(input int cur, input bit e, input bit u);
    return e && ((u && cur == M - 1) || (!u && cur == 0));
  endfunction

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input int dv);
    en = e; up = u; clr = c; load = l; d = W'(dv);
    #1;
  endtask

  task automatic tick();
    mwrap = m_tc(mq, en, up) && !clr && !load;
    mq    = m_next(mq, en, up, clr, load, int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got=%0d want=0", q); end
    checks++; if (qn !== '1) begin errors++; $display("FAIL reset_qn got=%h want=%h", qn, {W{1'b1}}); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_idle got=%b want=0", tc); end
    drive(1, 0, 0, 0, 0);
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%b want=1", tc); end
    @(posedge clk); #1;
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_hold_q got=%0d want=0", q); end
    @(negedge clk);
    rst = 1'b1;
    mq = 0; mwrap = 1'b0;
    drive(0, 1, 0, 0, 0);
    tick();
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_release_q got=%0d want=0", q); end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0, 1, 7);
    tick();
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL async_load7 got=%0d want=7", q); end
    drive(0, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (q !== '0) begin errors++; $display("FAIL async_q got=%0d want=0", q); end
    checks++; if (qn !== 4'hF) begin errors++; $display("FAIL async_qn got=%h want=F", qn); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL async_wrap got=%b want=0", wrap); end
    #1;
    rst = 1'b1;
    mq = 0; mwrap = 1'b0;
    drive(1, 1, 0, 0, 0);
    tick();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL async_resume got=%0d want=1", q); end
  endtask

  task automatic test_up_wrap();
    int pulses;
    pulses = 0;
    drive(0, 1, 1, 0, 0);
    tick();
    for (int i = 1; i <= M; i++) begin
      drive(1, 1, 0, 0, 0);
      checks++;
      if (tc !== (mq == M - 1)) begin errors++; $display("FAIL upwrap_tc step=%0d got=%b want=%b", i, tc, mq == M - 1); end
      tick();
      checks++;
      if (q !== W'(i % M)) begin errors++; $display("FAIL upwrap_q step=%0d got=%0d want=%0d", i, q, i % M); end
      checks++;
      if (wrap !== mwrap) begin errors++; $display("FAIL upwrap_wrap step=%0d got=%b want=%b", i, wrap, mwrap); end
      if (wrap === 1'b1) pulses++;
    end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL upwrap_final_wrap got=%b want=1", wrap); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL upwrap_pulses got=%0d want=1", pulses); end
    drive(0, 1, 0, 0, 0);
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL upwrap_pulse_len got=%b want=0", wrap); end
  endtask

  task automatic test_down_wrap();
    drive(1, 0, 0, 0, 0);
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL downwrap_tc got=%b want=1", tc); end
    tick();
    checks++; if (q !== W'(M - 1)) begin errors++; $display("FAIL downwrap_q got=%0d want=%0d", q, M - 1); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL downwrap_wrap got=%b want=1", wrap); end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL downwrap_pulse_len got=%b want=0", wrap); end
    checks++; if (q !== W'(M - 1)) begin errors++; $display("FAIL downwrap_hold got=%0d want=%0d", q, M - 1); end
  endtask

  task automatic test_priority();
    drive(0, 1, 0, 1, M - 1);
    tick();
    drive(1, 1, 1, 1, 5);
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL prio_tc got=%b want=1", tc); end
    tick();
    checks++; if (q !== '0) begin errors++; $display("FAIL prio_clr got=%0d want=0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL prio_wrap got=%b want=0", wrap); end
    drive(0, 1, 0, 1, 12);
    tick();
    checks++; if (q !== W'(M - 1)) begin errors++; $display("FAIL prio_clamp got=%0d want=%0d", q, M - 1); end
    drive(1, 1, 0, 1, 3);
    tick();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL prio_load3 got=%0d want=3", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL prio_load_wrap got=%b want=0", wrap); end
  endtask

  task automatic test_direction_flip();
    drive(0, 1, 0, 1, 4);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, (i % 2) == 0, 0, 0, 0);
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL flip_tc step=%0d got=%b want=0", i, tc); end
      tick();
      checks++;
      if (q !== (((i % 2) == 0) ? 4'd5 : 4'd4)) begin
        errors++; $display("FAIL flip_q step=%0d got=%0d want=%0d", i, q, ((i % 2) == 0) ? 5 : 4);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] eq;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, (1 << W) - 1));
      checks++;
      if (tc !== m_tc(mq, en, up)) begin errors++; $display("FAIL rand_tc iter=%0d got=%b want=%b", i, tc, m_tc(mq, en, up)); end
      tick();
      eq = W'(mq);
      checks++;
      if (q !== eq) begin errors++; $display("FAIL rand_q iter=%0d got=%0d want=%0d", i, q, mq); end
      checks++;
      if (qn !== ~eq) begin errors++; $display("FAIL rand_qn iter=%0d got=%h want=%h", i, qn, ~eq); end
      checks++;
      if (wrap !== mwrap) begin errors++; $display("FAIL rand_wrap iter=%0d got=%b want=%b", i, wrap, mwrap); end
    end
  endtask

  task automatic test_cascade();
    int pulses, over, val, bad_val;
    pulses = 0; over = 0; bad_val = 0;
    c_clr = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    c_clr = 1'b0;
    checks++;
    if ({c_q2, c_q1, c_q0} !== '0) begin errors++; $display("FAIL cascade_clear got=%0d%0d%0d want=000", c_q2, c_q1, c_q0); end
    for (int n = 1; n <= DIGIT_MOD ** MS_DIGITS; n++) begin
      c_en = 1'b1;
      @(posedge clk); #1;
      if (c_q0 > 4'd9 || c_q1 > 4'd9 || c_q2 > 4'd9) over++;
      val = int'(c_q2) * 100 + int'(c_q1) * 10 + int'(c_q0);
      if (val != n % 1000) bad_val++;
      if (c_w2 === 1'b1) pulses++;
    end
    c_en = 1'b0;
    checks++; if (bad_val != 0) begin errors++; $display("FAIL cascade_value got=%0d bad_cycles want=0", bad_val); end
    checks++; if (over != 0) begin errors++; $display("FAIL cascade_digit_range got=%0d bad_cycles want=0", over); end
    checks++;
    if ({c_q2, c_q1, c_q0} !== '0) begin errors++; $display("FAIL cascade_final got=%0d%0d%0d want=000", c_q2, c_q1, c_q0); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL cascade_top_wrap got=%0d want=1", pulses); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_direction_flip();
    test_random();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
